// File: rtl/pipeline_pkg.sv
// Shared widths and payload layouts for the fetch/decode/execute pipeline.
// Stage buffers carry these structs as opaque vectors sized with $bits().
package pipeline_pkg;

   localparam int ADDR_WIDTH        = 32;
   localparam int DATA_WIDTH        = 32;
   localparam int INSTRUCTION_WIDTH = 32;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0]        pc;
      logic [INSTRUCTION_WIDTH-1:0] instr;
   } fetch_payload_t;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic [6:0]            opcode;
      logic [4:0]            rd;
      logic [DATA_WIDTH-1:0] rs1_value;
      logic [DATA_WIDTH-1:0] rs2_value;
      logic [DATA_WIDTH-1:0] imm;
   } decode_payload_t;

endpackage

// File: rtl/pipeline_stage_buffer.sv
// Small FIFO stage register between two pipeline stages using the stall/done handshake,
// with a hold veto on the output side and a synchronous flush for redirects.
module pipeline_stage_buffer
   import pipeline_pkg::*;
#(
   parameter int PAYLOAD_WIDTH  = $bits(fetch_payload_t),
   parameter int DEPTH          = 2,
   parameter int CUT_STALL_PATH = 0,
   localparam int COUNT_WIDTH   = $clog2(DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     prev_done,
   output logic                     stall_prev,
   input  logic [PAYLOAD_WIDTH-1:0] payload_in,
   output logic                     done_next,
   input  logic                     next_stall,
   output logic [PAYLOAD_WIDTH-1:0] payload_out,
   input  logic                     hold,
   input  logic                     flush,
   output logic [COUNT_WIDTH-1:0]   occupancy
);

   // A single-entry buffer keeps a 1-bit pointer that never moves.
   localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_WIDTH-1:0] PTR_STEP = PTR_WIDTH'((DEPTH > 1) ? 1 : 0);

   logic [PAYLOAD_WIDTH-1:0] mem [DEPTH];
   logic [PTR_WIDTH-1:0]     rd_ptr;
   logic [PTR_WIDTH-1:0]     wr_ptr;
   logic [COUNT_WIDTH-1:0]   count;
   logic                     full;
   logic                     transfer_prev;
   logic                     transfer_next;

   assign full          = (count == COUNT_WIDTH'(DEPTH));
   assign done_next     = rst_n && (count != '0) && !hold && !flush;
   assign transfer_next = done_next && !next_stall;
   assign transfer_prev = prev_done && !stall_prev;
   assign payload_out   = mem[rd_ptr];
   assign occupancy     = count;

   // The cut variant trades same-cycle refill of a full buffer for a purely registered stall.
   if (CUT_STALL_PATH != 0) begin : g_cut_stall
      assign stall_prev = !rst_n || flush || full;
   end else begin : g_comb_stall
      assign stall_prev = !rst_n || flush || (full && !transfer_next);
   end

   always_ff @(posedge clk) begin
      if (transfer_prev) begin
         mem[wr_ptr] <= payload_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (transfer_prev) begin
            wr_ptr <= wr_ptr + PTR_STEP;
         end
         if (transfer_next) begin
            rd_ptr <= rd_ptr + PTR_STEP;
         end
         if (transfer_prev && !transfer_next) begin
            count <= count + 1'b1;
         end else if (!transfer_prev && transfer_next) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_stage_buffer.sv
// Directed and streaming checks of pipeline_stage_buffer in three configurations
// (DEPTH=2 combinational stall, DEPTH=2 cut stall, DEPTH=4) sharing one input set.
module tb_pipeline_stage_buffer;

   localparam int W = 16;

   logic         clk;
   logic         rst_n;
   logic         prev_done;
   logic [W-1:0] payload_in;
   logic         next_stall;
   logic         hold;
   logic         flush;

   logic         a_stall, b_stall, c_stall;
   logic         a_done, b_done, c_done;
   logic [W-1:0] a_out, b_out, c_out;
   logic [1:0]   a_occ, b_occ;
   logic [2:0]   c_occ;

   int checks = 0;
   int errors = 0;

   pipeline_stage_buffer #(.PAYLOAD_WIDTH(W), .DEPTH(2), .CUT_STALL_PATH(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .prev_done(prev_done), .stall_prev(a_stall),
      .payload_in(payload_in), .done_next(a_done), .next_stall(next_stall),
      .payload_out(a_out), .hold(hold), .flush(flush), .occupancy(a_occ)
   );

   pipeline_stage_buffer #(.PAYLOAD_WIDTH(W), .DEPTH(2), .CUT_STALL_PATH(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .prev_done(prev_done), .stall_prev(b_stall),
      .payload_in(payload_in), .done_next(b_done), .next_stall(next_stall),
      .payload_out(b_out), .hold(hold), .flush(flush), .occupancy(b_occ)
   );

   pipeline_stage_buffer #(.PAYLOAD_WIDTH(W), .DEPTH(4), .CUT_STALL_PATH(0)) dut_c (
      .clk(clk), .rst_n(rst_n), .prev_done(prev_done), .stall_prev(c_stall),
      .payload_in(payload_in), .done_next(c_done), .next_stall(next_stall),
      .payload_out(c_out), .hold(hold), .flush(flush), .occupancy(c_occ)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic pd, input logic [W-1:0] pl, input logic ns,
                                input logic hd, input logic fl);
      prev_done  = pd;
      payload_in = pl;
      next_stall = ns;
      hold       = hd;
      flush      = fl;
      #1;
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Handshake invariants on every settled cycle outside reset
   always @(negedge clk) begin
      if (rst_n) begin
         checkOutput("a_occ_bound", 32'(a_occ <= 2'd2), 32'd1);
         checkOutput("c_occ_bound", 32'(c_occ <= 3'd4), 32'd1);
         checkOutput("a_no_accept_full",
                     32'(prev_done && !a_stall && a_occ == 2'd2 && !(a_done && !next_stall)), 32'd0);
         checkOutput("b_no_accept_full",
                     32'(prev_done && !b_stall && b_occ == 2'd2 && !(b_done && !next_stall)), 32'd0);
         checkOutput("c_no_accept_full",
                     32'(prev_done && !c_stall && c_occ == 3'd4 && !(c_done && !next_stall)), 32'd0);
         if (flush) begin
            checkOutput("flush_done_a", 32'(a_done), 32'd0);
            checkOutput("flush_done_c", 32'(c_done), 32'd0);
         end
      end
   end

   logic [W-1:0] model_q[$];
   int           model_count;
   int           sent;
   int           received;
   int           cycles;
   logic         exp_done;
   logic         exp_stall;
   logic         pd;
   logic         ns;
   logic         hd;
   logic [W-1:0] pl;

   initial begin
      rst_n      = 1'b0;
      prev_done  = 1'b0;
      payload_in = '0;
      next_stall = 1'b0;
      hold       = 1'b0;
      flush      = 1'b0;
      #2;
      checkOutput("rst_a_stall", 32'(a_stall), 32'd1);
      checkOutput("rst_a_done", 32'(a_done), 32'd0);
      checkOutput("rst_a_occ", 32'(a_occ), 32'd0);
      checkOutput("rst_c_stall", 32'(c_stall), 32'd1);
      checkOutput("rst_c_occ", 32'(c_occ), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fill both DEPTH=2 buffers while downstream stalls
      applyStimulus(1'b1, 16'h000A, 1'b1, 1'b0, 1'b0);
      checkOutput("a_stall_empty", 32'(a_stall), 32'd0);
      checkOutput("a_done_empty", 32'(a_done), 32'd0);
      stepClock();
      applyStimulus(1'b1, 16'h000B, 1'b1, 1'b0, 1'b0);
      checkOutput("a_done_first", 32'(a_done), 32'd1);
      stepClock();
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checkOutput("a_occ_full", 32'(a_occ), 32'd2);
      checkOutput("b_occ_full", 32'(b_occ), 32'd2);
      checkOutput("a_stall_full", 32'(a_stall), 32'd1);
      checkOutput("b_stall_full", 32'(b_stall), 32'd1);
      checkOutput("a_head_A", 32'(a_out), 32'h000A);

      // Full buffer offered 0xC while downstream pops
      applyStimulus(1'b1, 16'h000C, 1'b0, 1'b0, 1'b0);
      checkOutput("a_stall_pop", 32'(a_stall), 32'd0);
      checkOutput("b_stall_pop", 32'(b_stall), 32'd1);
      checkOutput("a_pop_A", 32'(a_out), 32'h000A);
      checkOutput("b_pop_A", 32'(b_out), 32'h000A);
      stepClock();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkOutput("a_occ_swap", 32'(a_occ), 32'd2);
      checkOutput("b_occ_swap", 32'(b_occ), 32'd1);
      checkOutput("a_pop_B", 32'(a_out), 32'h000B);
      checkOutput("b_pop_B", 32'(b_out), 32'h000B);
      stepClock();
      checkOutput("a_pop_C", 32'(a_out), 32'h000C);
      checkOutput("a_done_C", 32'(a_done), 32'd1);
      checkOutput("b_done_empty", 32'(b_done), 32'd0);
      checkOutput("b_occ_empty", 32'(b_occ), 32'd0);
      stepClock();
      checkOutput("a_occ_drained", 32'(a_occ), 32'd0);
      checkOutput("a_done_drained", 32'(a_done), 32'd0);

      // Empty all buffers before the DEPTH=4 scenarios
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
      checkOutput("c_done_flush0", 32'(c_done), 32'd0);
      stepClock();
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checkOutput("c_occ_flush0", 32'(c_occ), 32'd0);

      for (int i = 1; i <= 3; i++) begin
         applyStimulus(1'b1, W'(i), 1'b1, 1'b0, 1'b0);
         stepClock();
      end
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checkOutput("c_occ_three", 32'(c_occ), 32'd3);

      // Flush with an upstream offer: nothing moves, buffer empties, flush held twice
      applyStimulus(1'b1, 16'h0099, 1'b0, 1'b0, 1'b1);
      checkOutput("c_stall_flush", 32'(c_stall), 32'd1);
      checkOutput("c_done_flush", 32'(c_done), 32'd0);
      checkOutput("a_stall_flush", 32'(a_stall), 32'd1);
      stepClock();
      applyStimulus(1'b1, 16'h0099, 1'b0, 1'b0, 1'b1);
      checkOutput("c_occ_flushed", 32'(c_occ), 32'd0);
      stepClock();
      checkOutput("c_occ_flush_held", 32'(c_occ), 32'd0);
      checkOutput("c_done_flush_held", 32'(c_done), 32'd0);
      applyStimulus(1'b1, 16'h0055, 1'b1, 1'b0, 1'b0);
      stepClock();
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
      checkOutput("c_first_55", 32'(c_out), 32'h0055);
      checkOutput("c_done_55", 32'(c_done), 32'd1);
      checkOutput("c_occ_55", 32'(c_occ), 32'd1);

      // Hold vetoes presentation but the buffer keeps accepting until full
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, W'(16'h0060 + i), 1'b0, 1'b1, 1'b0);
         checkOutput("c_done_hold", 32'(c_done), 32'd0);
         checkOutput("c_stall_hold", 32'(c_stall), 32'(i >= 3));
         stepClock();
         checkOutput("c_occ_hold", 32'(c_occ), 32'((i + 2 > 4) ? 4 : i + 2));
      end
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkOutput("c_after_hold_55", 32'(c_out), 32'h0055);
      checkOutput("c_done_unhold", 32'(c_done), 32'd1);
      stepClock();
      checkOutput("c_after_hold_60", 32'(c_out), 32'h0060);

      // Asynchronous reset in the middle of a cycle
      applyStimulus(1'b1, 16'h0070, 1'b0, 1'b1, 1'b0);
      checkOutput("c_occ_prereset", 32'(c_occ), 32'd3);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("c_occ_async_rst", 32'(c_occ), 32'd0);
      checkOutput("c_stall_async_rst", 32'(c_stall), 32'd1);
      checkOutput("c_done_async_rst", 32'(c_done), 32'd0);
      checkOutput("a_stall_async_rst", 32'(a_stall), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

      // Streaming through DEPTH=4 against a queue model
      model_count = 0;
      sent        = 0;
      received    = 0;
      cycles      = 0;
      while (received < 1000 && cycles < 20000) begin
         pd = (sent < 1000) && ($urandom_range(0, 9) < 7);
         ns = ($urandom_range(0, 9) < 3);
         hd = ($urandom_range(0, 9) < 2);
         pl = W'($urandom);
         applyStimulus(pd, pl, ns, hd, 1'b0);
         exp_done  = (model_count != 0) && !hd;
         exp_stall = (model_count == 4) && !(exp_done && !ns);
         checkOutput("s_done", 32'(c_done), 32'(exp_done));
         checkOutput("s_stall", 32'(c_stall), 32'(exp_stall));
         checkOutput("s_occ", 32'(c_occ), 32'(model_count));
         if (exp_done && !ns) begin
            checkOutput("s_payload", 32'(c_out), 32'(model_q[0]));
            void'(model_q.pop_front());
            model_count--;
            received++;
         end
         if (pd && !exp_stall) begin
            model_q.push_back(pl);
            model_count++;
            sent++;
         end
         stepClock();
         cycles++;
      end
      checkOutput("s_received", 32'(received), 32'd1000);
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      checkOutput("s_occ_end", 32'(c_occ), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
